// File: rtl/popcount_frame_sequencer.sv
// Frame sequencer: feeds 32-bit words to an external combinational popcount
// datapath and accumulates the returned counts into a saturating frame total.
module popcount_frame_sequencer #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [ACC_W-1:0] threshold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_word,
  output logic [31:0]      pc_word,
  input  logic [5:0]       pc_count,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] total,
  output logic             sat,
  output logic             above
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [LEN_W-1:0] remaining;
  logic [ACC_W-1:0] thr_q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W:0]   acc_sum;
  logic             stage_v;
  logic             sat_q;
  logic             sat_nxt;
  logic             above_q;
  logic             accept;

  assign in_ready = (state == S_RUN) && (remaining != '0);
  assign accept   = in_valid & in_ready;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign total    = acc;
  assign sat      = sat_q;
  assign above    = above_q;

  // One extra sum bit catches overflow; the accumulator then pins at all-ones.
  assign acc_sum = {1'b0, acc} + {{(ACC_W - 5){1'b0}}, pc_count};

  always_comb begin
    acc_nxt = acc;
    sat_nxt = sat_q;
    if (stage_v) begin
      if (acc_sum[ACC_W]) begin
        acc_nxt = '1;
        sat_nxt = 1'b1;
      end else begin
        acc_nxt = acc_sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      thr_q     <= '0;
      acc       <= '0;
      stage_v   <= 1'b0;
      sat_q     <= 1'b0;
      above_q   <= 1'b0;
      pc_word   <= '0;
    end else begin
      stage_v <= accept;
      acc     <= acc_nxt;
      sat_q   <= sat_nxt;
      if (accept) pc_word <= in_word;
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= frame_len;
            thr_q     <= threshold;
            acc       <= '0;
            sat_q     <= 1'b0;
            if (frame_len == '0) begin
              state   <= S_DONE;
              above_q <= (threshold == '0);
            end else begin
              state   <= S_RUN;
              above_q <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) state <= S_DRAIN;
          end
        end
        // The final add lands this edge, so compare against the post-add value.
        S_DRAIN: begin
          state   <= S_DONE;
          above_q <= (acc_nxt >= thr_q);
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/popcount_frame_sequencer.md
# popcount_frame_sequencer

Sequencer that streams a frame of 32-bit words through the team's shared combinational 32-input population-count datapath (32 data inputs, 6-bit count out) and accumulates the per-word counts into a frame total. It sits between a valid/ready word source and that datapath. It owns the frame FSM, a one-word input register feeding the datapath, a saturating accumulator and a threshold comparison. The returned count is added exactly as delivered; any approximation error in the count unit passes through uncorrected.

## Interface
Parameters:
- ACC_W, 16, accumulator/total width (minimum 6)
- LEN_W, 8, frame-length field width

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  frame start request, sampled in IDLE only
- frame_len  input  LEN_W  number of words in the frame, sampled with start
- threshold  input  ACC_W  compare value, sampled with start
- in_valid  input  1  source word valid
- in_ready  output  1  sequencer accepts a word this cycle
- in_word  input  32  source word
- pc_word  output  32  registered word driven to the popcount datapath inputs 0..31
- pc_count  input  6  count returned combinationally by the datapath for pc_word
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse: frame complete, total valid
- total  output  ACC_W  frame sum of pc_count, saturating
- sat  output  1  sticky per frame: accumulator saturated
- above  output  1  total >= sampled threshold, updated with done

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0. On start, latch frame_len into remaining and threshold into thr_q, clear acc and sat. If frame_len==0, go to DONE; otherwise go to RUN.
- RUN: in_ready = (remaining != 0). Accept = in_valid & in_ready. On accept: pc_word <= in_word, stage_v <= 1, remaining decrements. When no word is accepted, stage_v <= 0. Accepting the last word (remaining==1) moves the FSM to DRAIN.
- Accumulate: every cycle with stage_v=1, acc <= acc + pc_count, zero-extended. If the true sum exceeds 2^ACC_W-1, acc becomes all-ones and sat is set. sat stays set until the next start.
- DRAIN: the final stage_v add completes this cycle; stage_v <= 0. Go to DONE.
- DONE: done=1 for exactly one cycle. total shows acc. above = (acc >= thr_q), registered on entry. Next state IDLE.
- total, sat and above hold their values until the next accepted start.
- start outside IDLE is ignored, including during the DONE cycle.
- in_valid is ignored outside RUN. pc_word holds its last value when no word is accepted.

## Timing
- Reset (rst_n=0, takes effect asynchronously): state=IDLE, in_ready=0, pc_word=0, stage_v=0, busy=0, done=0, total=0, sat=0, above=0, remaining=0.
- Deassertion of rst_n is synchronized externally. The first edge after release may sample start.
- start high at edge 0 moves to RUN; in_ready is high from cycle 1.
- A word accepted at edge k appears on pc_word after edge k. Its count is added into acc at edge k+1.
- Throughput is one word per cycle. The source may stall freely; bubbles cost no extra latency beyond the stall.
- Last word accepted at edge L: DRAIN in cycle L+1, accumulated at edge L+1, DONE (done=1) in cycle L+2, IDLE at L+3.
- Zero-length frame: start at edge 0 gives done=1 in cycle 1 with total=0, sat=0, above=(threshold==0).
- Reset asserted mid-frame aborts immediately to reset values. No done pulse is produced. Words already accepted are lost.

## Test plan
- Three words 0xFFFFFFFF, 0x00000000, 0x0000000F back-to-back, threshold=36 -> done one cycle after DRAIN, total=36, above=1, sat=0, in_ready low after the third accept.
- Same frame with in_valid gaps of 0, 2 and 5 cycles between words -> total=36. done arrives 2 cycles after the last accept. No word is double-counted during stalls.
- frame_len=0, threshold=1 -> done in cycle 1, total=0, above=0. in_ready is never high.
- ACC_W=6 with three 0xFFFFFFFF words -> total=63, sat=1. The next frame with one word 0x1 gives total=1, sat=0.
- start pulsed while busy, with a different frame_len -> ignored. The original frame length and total are preserved.
- rst_n low two cycles after the second accept of a 4-word frame -> all outputs return to reset values immediately, no done pulse. A new 1-word 0x80000001 frame then gives total=2.
